// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic {
        IDLE,
        SHIFT
    } b2b_state_t;

    localparam bcd_digit_t BCD_NINE = 4'h9;

    // Double-dabble correction: a digit that would reach >=10 after doubling is pre-biased by 3.
    function automatic bcd_digit_t add3_if_ge5(input bcd_digit_t d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    // Elaboration-time 10**n, used as the overflow threshold.
    function automatic longint unsigned pow10(input int n);
        longint unsigned p;
        p = 1;
        for (int i = 0; i < n; i++) begin
            p = p * 10;
        end
        return p;
    endfunction

endpackage

// File: rtl/bcd_add3_cell.sv
// Combinational per-digit add-3 correction cell for the double-dabble datapath.
module bcd_add3_cell
    import bcd_pkg::*;
(
    input  bcd_digit_t d,
    output bcd_digit_t q
);

    assign q = add3_if_ge5(d);

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-packed-BCD converter (shift-and-add-3, one bit per clock).
// Define BCD_SAT_EN to saturate bcd_out to all nines when the value does not fit in NDIG digits.
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W = 7,
    parameter int NDIG  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [BIN_W-1:0]  bin_in,
    output logic              busy,
    output logic              done,
    output logic [4*NDIG-1:0] bcd_out,
    output logic              ovf
);

    localparam int               CNT_W = $clog2(BIN_W);
    localparam int               DW    = 4 * NDIG;
    localparam longint unsigned  LIMIT = pow10(NDIG);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(BIN_W - 1);

    b2b_state_t       state, state_n;
    logic [BIN_W-1:0] sreg;
    logic [DW-1:0]    dreg;
    logic [DW-1:0]    dcor;
    logic [DW-1:0]    dnext;
    logic [CNT_W-1:0] cnt;
    logic             ovf_n;
    logic             ovf_in;
    logic             last;
    logic             unused_carry;

    for (genvar g = 0; g < NDIG; g++) begin : g_cell
        bcd_add3_cell u_cell (
            .d (dreg[4*g +: 4]),
            .q (dcor[4*g +: 4])
        );
    end

    // The bit leaving the top digit is worth 10**NDIG; dropping it yields bin_in mod 10**NDIG.
    assign {unused_carry, dnext} = {dcor, sreg[BIN_W-1]};

    assign ovf_in = (64'(bin_in) >= LIMIT);
    assign last   = (cnt == LAST);
    assign busy   = (state == SHIFT);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // NOTE: next-state gets a default first so no path through the block can infer a latch.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = SHIFT;
            SHIFT:   if (last)  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg    <= '0;
            dreg    <= '0;
            cnt     <= '0;
            ovf_n   <= 1'b0;
            bcd_out <= '0;
            ovf     <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    sreg  <= bin_in;
                    dreg  <= '0;
                    cnt   <= '0;
                    ovf_n <= ovf_in;
                end
            end else begin
                sreg <= {sreg[BIN_W-2:0], 1'b0};
                dreg <= dnext;
                cnt  <= cnt + CNT_W'(1);
                if (last) begin
                    done <= 1'b1;
                    ovf  <= ovf_n;
`ifdef BCD_SAT_EN
                    bcd_out <= ovf_n ? {NDIG{BCD_NINE}} : dnext;
`else
                    bcd_out <= dnext;
`endif
                end
            end
        end
    end

endmodule
